cpu_fetch_ctrl: RTL

Multi-cycle sequencer for the CPU front end. It issues instruction fetches to the memory bus, strobes the write enable of the instruction register so the register captures the returned word, and signals decode once the register holds a new instruction. It then waits for the execute stage to finish before fetching again. It also detects misaligned PCs, bus errors and fetch timeouts, and holds a fault state until software or the trap logic clears it.

---
 rtl/cpu_fetch_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_fetch_ctrl.sv
// Front-end fetch sequencer: issues instruction fetches, strobes the IR, hands off to
// decode/execute and traps misaligned PCs, bus errors and fetch timeouts.
module cpu_fetch_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [31:0]      pc,
   input  logic             flush,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   input  logic             mem_ack,
   input  logic             mem_err,
   output logic             ir_wr,
   output logic             decode_valid,
   input  logic             exec_done,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [31:0]      fault_addr,
   input  logic             fault_clr,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_FAULT
   } state_t;

   localparam logic [1:0]  CAUSE_NONE    = 2'd0;
   localparam logic [1:0]  CAUSE_MISALGN = 2'd1;
   localparam logic [1:0]  CAUSE_BUSERR  = 2'd2;
   localparam logic [1:0]  CAUSE_TIMEOUT = 2'd3;
   // Counter value seen during the last permitted FETCH cycle (cycle TIMEOUT_CYCLES).
   localparam logic [15:0] WAIT_LAST     = 16'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [15:0]      wait_q, wait_d;
   logic [1:0]       cause_q, cause_d;
   logic [31:0]      faddr_q, faddr_d;
   logic [CNT_W-1:0] ret_q, ret_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wait_q  <= '0;
         cause_q <= CAUSE_NONE;
         faddr_q <= '0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
         faddr_q <= faddr_d;
         ret_q   <= ret_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wait_d  = wait_q;
      cause_d = cause_q;
      faddr_d = faddr_q;
      ret_d   = ret_q;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (run) begin
               if (pc[1:0] != 2'b00) begin
                  state_d = S_FAULT;
                  cause_d = CAUSE_MISALGN;
                  faddr_d = pc;
               end else begin
                  state_d = S_FETCH;
                  addr_d  = pc;
                  wait_d  = '0;
               end
            end
         end
         S_FETCH: begin
            wait_d = wait_q + 16'd1;
            // An ack in the final permitted cycle wins over the timeout.
            if (flush) begin
               state_d = S_IDLE;
            end else if (mem_ack) begin
               if (mem_err) begin
                  state_d = S_FAULT;
                  cause_d = CAUSE_BUSERR;
                  faddr_d = addr_q;
               end else begin
                  state_d = S_DECODE;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
               cause_d = CAUSE_TIMEOUT;
               faddr_d = addr_q;
            end
         end
         S_DECODE: begin
            state_d = flush ? S_IDLE : S_EXEC;
         end
         S_EXEC: begin
            if (flush) begin
               state_d = S_IDLE;
            end else if (exec_done) begin
               state_d = S_IDLE;
               ret_d   = ret_q + 1'b1;
            end
         end
         S_FAULT: begin
            if (fault_clr) begin
               state_d = S_IDLE;
               cause_d = CAUSE_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Moore outputs decode the state register directly, so async reset drops them at once.
   assign mem_req      = (state_q == S_FETCH);
   assign mem_addr     = addr_q;
   assign ir_wr        = (state_q == S_FETCH) && mem_ack && !mem_err && !flush;
   assign decode_valid = (state_q == S_DECODE);
   assign fault        = (state_q == S_FAULT);
   assign fault_cause  = cause_q;
   assign fault_addr   = faddr_q;
   assign retired      = ret_q;

endmodule
